// File: rtl/aes_inv_key_gen.sv
// ----------------------------------------------------------------------------
// aes_inv_key_gen
//
// Reverse-direction AES-128 key scheduler. It loads the round-NR key and walks
// the key schedule backwards. It emits round keys NR, NR-1, ..., 0, one key per
// valid/ready beat. The S-box is outside this block and is reached through the
// sub_o / sub_i word port, so one S-box can also serve the forward key
// generator.
//
// Ports
//   clk          clock
//   nrst         synchronous active-low reset (takes effect regardless of en)
//   en           clock enable; when low every register holds, FSM included
//   start_i      load request, sampled only in IDLE with en=1
//   key_i        round-NR key, word0=[127:96] .. word3=[31:0], byte0=[31:24]
//   rk_valid_o   round key valid
//   rk_ready_i   consumer ready
//   rk_o         current round key (same word/byte order as key_i)
//   rk_rnd_o     round index of rk_o, NR down to 0
//   busy_o       high in any state other than IDLE
//   done_o       one-cycle pulse after the round-0 key is accepted
//   sub_o        RotWord of the candidate previous word3, sent to the S-box
//   sub_i        SubWord(sub_o), combinational return in the same cycle
//   dbg_state_o  FSM state (0 = IDLE, 1 = EMIT) for observation
//
// Handshake: a beat completes on a rising clk edge where rk_valid_o=1,
// rk_ready_i=1 and en=1. While a beat is not completing, rk_o and rk_rnd_o
// hold stable. A ready seen while en=0 does not count.
// ----------------------------------------------------------------------------
module aes_inv_key_gen #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         en,
   input  logic         start_i,
   input  logic [127:0] key_i,
   output logic         rk_valid_o,
   input  logic         rk_ready_i,
   output logic [127:0] rk_o,
   output logic [3:0]   rk_rnd_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [31:0]  sub_o,
   input  logic [31:0]  sub_i,
   output logic         dbg_state_o
);

   generate
      if (NR < 1 || NR > 10) begin : g_bad_nr
         $error("aes_inv_key_gen: NR must be in 1..10");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   state_t         r_state;
   logic [127:0]   r_rk;
   logic [3:0]     r_rnd;
   logic           r_valid;
   logic           r_done;

   state_t         w_next_state;
   logic [127:0]   w_next_rk;
   logic [3:0]     w_next_rnd;
   logic           w_next_valid;
   logic           w_next_done;

   logic [31:0]    w_w0, w_w1, w_w2, w_w3;
   logic [31:0]    w_p0, w_p1, w_p2, w_p3;
   logic [127:0]   w_prev;

   // Round constant for the step that produced round r from round r-1.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Backward step. The forward relation is w[i] = w[i-1] ^ w[i-4]. So the
   // upper three previous words come from plain XORs of neighbours. The
   // previous word0 needs SubWord(RotWord(previous word3)), which is w_p3.
   assign w_w0   = r_rk[127:96];
   assign w_w1   = r_rk[95:64];
   assign w_w2   = r_rk[63:32];
   assign w_w3   = r_rk[31:0];
   assign w_p3   = w_w3 ^ w_w2;
   assign w_p2   = w_w2 ^ w_w1;
   assign w_p1   = w_w1 ^ w_w0;
   assign sub_o  = {w_p3[23:0], w_p3[31:24]};
   assign w_p0   = w_w0 ^ sub_i ^ {rcon(r_rnd), 24'h000000};
   assign w_prev = {w_p0, w_p1, w_p2, w_p3};

   always_comb begin
      w_next_state = r_state;
      w_next_rk    = r_rk;
      w_next_rnd   = r_rnd;
      w_next_valid = r_valid;
      w_next_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_next_rk    = key_i;
               w_next_rnd   = 4'(NR);
               w_next_valid = 1'b1;
               w_next_state = ST_EMIT;
            end
         end
         ST_EMIT: begin
            // start_i is deliberately not looked at here: no restart mid-walk.
            if (rk_ready_i) begin
               if (r_rnd == 4'd0) begin
                  w_next_valid = 1'b0;
                  w_next_done  = 1'b1;
                  w_next_state = ST_IDLE;
               end else begin
                  w_next_rk  = w_prev;
                  w_next_rnd = r_rnd - 4'd1;
               end
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
         r_rk    <= '0;
         r_rnd   <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else if (en) begin
         r_state <= w_next_state;
         r_rk    <= w_next_rk;
         r_rnd   <= w_next_rnd;
         r_valid <= w_next_valid;
         r_done  <= w_next_done;
      end
   end

   assign rk_valid_o  = r_valid;
   assign rk_o        = r_rk;
   assign rk_rnd_o    = r_rnd;
   assign busy_o      = (r_state != ST_IDLE);
   assign done_o      = r_done;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_aes_inv_key_gen.sv
module tb_aes_inv_key_gen;

   logic         clk = 1'b0;
   logic         nrst, en;
   // NR=10 instance
   logic         start, ready;
   logic [127:0] key;
   logic         valid, busy, done, dbg;
   logic [127:0] rk;
   logic [3:0]   rnd;
   logic [31:0]  sub_out, sub_in;
   // NR=1 instance
   logic         start1, ready1;
   logic [127:0] key1;
   logic         valid1, busy1, done1, dbg1;
   logic [127:0] rk1;
   logic [3:0]   rnd1;
   logic [31:0]  sub_out1, sub_in1;

   int total = 0;
   int bad   = 0;

   logic [127:0] cur_sched [0:10];
   logic [127:0] fips      [0:10];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   aes_inv_key_gen #(.NR(10)) u_dut (
      .clk(clk), .nrst(nrst), .en(en), .start_i(start), .key_i(key),
      .rk_valid_o(valid), .rk_ready_i(ready), .rk_o(rk), .rk_rnd_o(rnd),
      .busy_o(busy), .done_o(done), .sub_o(sub_out), .sub_i(sub_in),
      .dbg_state_o(dbg)
   );

   aes_inv_key_gen #(.NR(1)) u_dut1 (
      .clk(clk), .nrst(nrst), .en(en), .start_i(start1), .key_i(key1),
      .rk_valid_o(valid1), .rk_ready_i(ready1), .rk_o(rk1), .rk_rnd_o(rnd1),
      .busy_o(busy1), .done_o(done1), .sub_o(sub_out1), .sub_i(sub_in1),
      .dbg_state_o(dbg1)
   );

   // ---------------- AES arithmetic (reference) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box = affine transform of the GF(2^8) multiplicative inverse (x^254).
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv, s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rotword(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Standard forward AES-128 key expansion from the cipher key.
   task automatic expand(input logic [127:0] k, output logic [127:0] rks [0:10]);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = subword(rotword(t)) ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // External S-box for both instances.
   always_comb sub_in  = subword(sub_out);
   always_comb sub_in1 = subword(sub_out1);

   // ---------------- scoreboard helper ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model + compare (NR=10 instance) ----------------
   // exp_q holds the keys still to be delivered, front = current. Its size
   // minus one is the round number that must be shown.
   logic [127:0] exp_q[$];
   logic m_busy = 1'b0;
   logic m_done = 1'b0;
   logic m_zero = 1'b1;

   always @(negedge clk) begin
      chk("valid", {127'd0, valid}, {127'd0, m_busy});
      chk("busy",  {127'd0, busy},  {127'd0, m_busy});
      chk("done",  {127'd0, done},  {127'd0, m_done});
      if (m_zero) begin
         chk("rst_rk",  rk, 128'd0);
         chk("rst_rnd", {124'd0, rnd}, 128'd0);
      end
      if (m_busy && exp_q.size() > 0) begin
         chk("rk",  rk, exp_q[0]);
         chk("rnd", {124'd0, rnd}, 128'(exp_q.size() - 1));
         if (exp_q.size() > 1)
            chk("sub_o", {96'd0, sub_out}, {96'd0, rotword(exp_q[1][31:0])});
      end
      // effect of the coming rising edge
      if (!nrst) begin
         m_busy = 1'b0; m_done = 1'b0; m_zero = 1'b1;
         exp_q.delete();
      end else if (en) begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               for (int r = 10; r >= 0; r--) exp_q.push_back(cur_sched[r]);
               m_busy = 1'b1;
               m_zero = 1'b0;
            end
         end else if (ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] k0);
      expand(k0, cur_sched);
      en = 1'b1; start = 1'b1; key = cur_sched[10];
      step();
      start = 1'b0;
   endtask

   task automatic wait_rnd(input logic [3:0] r);
      for (int n = 0; n < 40 && rnd != r; n++) step();
      chk("wait_rnd", {124'd0, rnd}, {124'd0, r});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 200) begin step(); n++; end
      chk("wait_idle", {127'd0, busy}, 128'd0);
      step(); step();
   endtask

   task automatic run_rand(input logic [127:0] k0);
      int n;
      logic fin;
      do_start(k0);
      fin = 1'b0;
      for (n = 0; n < 400 && !fin; n++) begin
         en    = (32'($urandom_range(0, 9)) != 0);
         ready = (32'($urandom_range(0, 2)) != 0);
         start = (32'($urandom_range(0, 7)) == 0);
         key   = {$urandom, $urandom, $urandom, $urandom};
         step();
         if (!busy) fin = 1'b1;
      end
      start = 1'b0; en = 1'b1; ready = 1'b1;
      chk("rand_finish", {127'd0, fin}, 128'd1);
      step(); step();
   endtask

   // ---------------- main stimulus ----------------
   initial begin
      nrst = 1'b0; en = 1'b1; start = 1'b0; ready = 1'b1; key = '0;
      start1 = 1'b0; ready1 = 1'b1; key1 = '0;
      expand(128'h2b7e151628aed2a6abf7158809cf4f3c, fips);
      cur_sched = fips;
      // pin the reference model to FIPS-197 values
      chk("pin_rk10", fips[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk("pin_rk9",  fips[9],  128'hac7766f319fadc2128d12941575c006e);
      chk("pin_rk1",  fips[1],  128'ha0fafe1788542cb123a339392a6c7605);
      repeat (3) step();
      nrst = 1'b1;
      step();

      // FIPS vector at full throughput
      do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("fips_first", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      wait_idle();
      chk("fips_last", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // backpressure at round 9
      do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_rnd(4'd9);
      ready = 1'b0;
      repeat (5) begin
         step();
         chk("bp_rk", rk, 128'hac7766f319fadc2128d12941575c006e);
         chk("bp_rnd", {124'd0, rnd}, 128'd9);
      end
      ready = 1'b1;
      wait_idle();

      // clock enable low mid-sequence with ready high
      do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_rnd(4'd7);
      en = 1'b0;
      repeat (3) begin
         step();
         chk("en_hold_rnd", {124'd0, rnd}, 128'd7);
      end
      en = 1'b1;
      wait_idle();

      // start with a different key while busy is ignored
      do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_rnd(4'd4);
      start = 1'b1; key = 128'h00112233445566778899aabbccddeeff;
      step();
      start = 1'b0;
      wait_idle();
      chk("ign_start_last", rk, 128'h2b7e151628aed2a6abf7158809cf4f3c);

      // reset mid-operation, then fresh run
      do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_rnd(4'd6);
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      chk("rst_mid_rk", rk, 128'd0);
      chk("rst_mid_busy", {127'd0, busy}, 128'd0);
      step();
      do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_idle();

      // randomized keys with random en/ready/start noise
      for (int t = 0; t < 16; t++)
         run_rand({$urandom, $urandom, $urandom, $urandom});

      // NR=1 instance
      start1 = 1'b1; key1 = 128'ha0fafe1788542cb123a339392a6c7605; ready1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("nr1_v1",   {127'd0, valid1}, 128'd1);
      chk("nr1_rnd1", {124'd0, rnd1}, 128'd1);
      chk("nr1_rk1",  rk1, 128'ha0fafe1788542cb123a339392a6c7605);
      chk("nr1_sub",  {96'd0, sub_out1}, 128'hcf4f3c09);
      chk("nr1_busy", {127'd0, busy1}, 128'd1);
      step();
      chk("nr1_rnd0", {124'd0, rnd1}, 128'd0);
      chk("nr1_rk0",  rk1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      chk("nr1_v0",   {127'd0, valid1}, 128'd1);
      step();
      chk("nr1_done", {127'd0, done1}, 128'd1);
      chk("nr1_idle", {127'd0, busy1}, 128'd0);
      chk("nr1_vlow", {127'd0, valid1}, 128'd0);
      step();
      chk("nr1_done_low", {127'd0, done1}, 128'd0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
